// File: rtl/dmem_store_buffer_if.sv
// Bus bundle between the MEM stage, the store buffer and the backing data RAM.
// The store buffer uses the slave view; the core/RAM side uses the master view.
interface dmem_store_buffer_if;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic        dmem_we;
  logic [2:0]  dmem_size;
  logic [63:0] dmem_rdata;
  logic [63:0] mem_rd_addr;
  logic [63:0] mem_rd_data;
  logic        mem_wr_valid;
  logic        mem_wr_ready;
  logic [63:0] mem_wr_addr;
  logic [63:0] mem_wr_data;
  logic [7:0]  mem_wr_strb;

  modport slave (
    input  dmem_addr, dmem_wdata, dmem_we, dmem_size, mem_rd_data, mem_wr_ready,
    output dmem_rdata, mem_rd_addr, mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_strb
  );

  modport master (
    output dmem_addr, dmem_wdata, dmem_we, dmem_size, mem_rd_data, mem_wr_ready,
    input  dmem_rdata, mem_rd_addr, mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_strb
  );
endinterface

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer with store-to-load forwarding and load formatting
// between the core's data-memory port and the backing data RAM.
module dmem_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  dmem_store_buffer_if.slave         bus,
  output logic [$clog2(DEPTH+1)-1:0] sb_count,
  output logic                       sb_full,
  output logic                       sb_empty,
  output logic                       err_misaligned,
  output logic                       err_overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [60:0]   entAddr_q [DEPTH];
  logic [63:0]   entData_q [DEPTH];
  logic [7:0]    entStrb_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          errMis_q, errMis_d;
  logic          errOvf_q, errOvf_d;

  logic [2:0]  offset;
  logic        aligned;
  logic        isStore;
  logic        pop;
  logic        push;
  logic [7:0]  storeStrb;
  logic [63:0] storeData;
  logic [63:0] merged;
  logic [63:0] field;
  logic [63:0] loadData;
  logic [PW-1:0] idx;

  assign offset   = bus.dmem_addr[2:0];
  assign sb_count = count_q;
  assign sb_full  = (count_q == CW'(DEPTH));
  assign sb_empty = (count_q == '0);
  assign err_misaligned = errMis_q;
  assign err_overflow   = errOvf_q;

  // Alignment depends only on the access width, so loads and stores share it.
  always_comb begin
    aligned = 1'b1;
    case (bus.dmem_size)
      3'd1, 3'd5: aligned = (offset[0] == 1'b0);
      3'd2, 3'd6: aligned = (offset[1:0] == 2'b00);
      3'd3:       aligned = (offset == 3'b000);
      3'd7:       aligned = 1'b0;
      default:    aligned = 1'b1;
    endcase
  end

  always_comb begin
    storeStrb = 8'hFF;
    case (bus.dmem_size[1:0])
      2'd0:    storeStrb = 8'h01 << offset;
      2'd1:    storeStrb = 8'h03 << offset;
      2'd2:    storeStrb = 8'h0F << offset;
      default: storeStrb = 8'hFF;
    endcase
  end

  assign storeData = bus.dmem_wdata << {offset, 3'b000};
  assign isStore   = bus.dmem_we && !bus.dmem_size[2];
  assign pop       = !sb_empty && bus.mem_wr_ready;
  assign push      = isStore && aligned && (!sb_full || pop);

  always_comb begin
    head_d   = pop  ? head_q + 1'b1 : head_q;
    tail_d   = push ? tail_q + 1'b1 : tail_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    errMis_d = errMis_q | (isStore && !aligned);
    errOvf_d = errOvf_q | (isStore && aligned && sb_full && !pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      errMis_q <= 1'b0;
      errOvf_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      errMis_q <= errMis_d;
      errOvf_q <= errOvf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      entAddr_q[tail_q] <= bus.dmem_addr[63:3];
      entData_q[tail_q] <= storeData;
      entStrb_q[tail_q] <= storeStrb;
    end
  end

  // Walk oldest to youngest so the youngest matching store wins each lane.
  always_comb begin
    merged = bus.mem_rd_data;
    idx    = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (i < int'(count_q) && entAddr_q[idx] == bus.dmem_addr[63:3]) begin
        for (int b = 0; b < 8; b++) begin
          if (entStrb_q[idx][b]) merged[8*b +: 8] = entData_q[idx][8*b +: 8];
        end
      end
    end
  end

  assign field = merged >> {offset, 3'b000};

  always_comb begin
    loadData = '0;
    if (aligned) begin
      case (bus.dmem_size)
        3'd0:    loadData = {{56{field[7]}},  field[7:0]};
        3'd1:    loadData = {{48{field[15]}}, field[15:0]};
        3'd2:    loadData = {{32{field[31]}}, field[31:0]};
        3'd3:    loadData = merged;
        3'd4:    loadData = {56'd0, field[7:0]};
        3'd5:    loadData = {48'd0, field[15:0]};
        3'd6:    loadData = {32'd0, field[31:0]};
        default: loadData = '0;
      endcase
    end
  end

  assign bus.dmem_rdata   = loadData;
  assign bus.mem_rd_addr  = {bus.dmem_addr[63:3], 3'b000};
  assign bus.mem_wr_valid = !sb_empty;
  assign bus.mem_wr_addr  = {entAddr_q[head_q], 3'b000};
  assign bus.mem_wr_data  = entData_q[head_q];
  assign bus.mem_wr_strb  = entStrb_q[head_q];
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Scoreboard bench for dmem_store_buffer: a queue-based reference model predicts
// loads, status and drained writes; a negedge monitor compares the DUT against them.
module tb_dmem_store_buffer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_store_buffer_if bus();
  logic [2:0] sbCount;
  logic sbFull, sbEmpty, errMis, errOvf;

  dmem_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .sb_count(sbCount), .sb_full(sbFull), .sb_empty(sbEmpty),
    .err_misaligned(errMis), .err_overflow(errOvf)
  );

  typedef struct packed {
    logic [60:0] da;
    logic [63:0] data;
    logic [7:0]  strb;
  } ent_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic [63:0] rdAddr;
    logic        valid;
    logic [2:0]  count;
    logic        mis;
    logic        ovf;
  } chk_t;

  ent_t mq[$];
  ent_t expWr[$];
  chk_t chkQ[$];
  logic [63:0] ram [4];
  logic mMis, mOvf;
  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the predicted outputs, then advance the model.
  task automatic applyStimulus(input logic r, input logic we, input logic [2:0] sz,
                               input logic [63:0] a, input logic [63:0] wd, input logic rdy);
    chk_t c;
    ent_t e;
    logic [7:0] by [8];
    logic [63:0] v;
    int off, n, sizeBefore;
    logic popNow;
    rst = r;
    bus.dmem_we = we;
    bus.dmem_size = sz;
    bus.dmem_addr = a;
    bus.dmem_wdata = wd;
    bus.mem_wr_ready = rdy;
    bus.mem_rd_data = ram[a[4:3]];

    for (int b = 0; b < 8; b++) by[b] = ram[a[4:3]][8*b +: 8];
    foreach (mq[i])
      if (mq[i].da == a[63:3])
        for (int b = 0; b < 8; b++)
          if (mq[i].strb[b]) by[b] = mq[i].data[8*b +: 8];

    off = int'(a[2:0]);
    n = (sz == 3'd7) ? 0 : (1 << sz[1:0]);
    v = 64'd0;
    if (n != 0 && (off % n) == 0) begin
      for (int k = n - 1; k >= 0; k--) v = (v << 8) | 64'(by[off + k]);
      if (sz < 3'd3 && by[off + n - 1][7]) v = v | (~64'd0 << (8 * n));
    end
    c.rdata  = v;
    c.rdAddr = {a[63:3], 3'b000};
    c.valid  = (mq.size() != 0);
    c.count  = 3'(mq.size());
    c.mis    = mMis;
    c.ovf    = mOvf;
    chkQ.push_back(c);

    @(posedge clk);
    if (r) begin
      mq.delete();
      expWr.delete();
      mMis = 1'b0;
      mOvf = 1'b0;
    end else begin
      sizeBefore = mq.size();
      popNow = (sizeBefore != 0) && rdy;
      if (popNow) begin
        e = mq.pop_front();
        for (int b = 0; b < 8; b++)
          if (e.strb[b]) ram[e.da[1:0]][8*b +: 8] = e.data[8*b +: 8];
      end
      if (we && sz < 3'd4) begin
        n = 1 << sz[1:0];
        if ((off % n) != 0) mMis = 1'b1;
        else if (sizeBefore == DEPTH && !popNow) mOvf = 1'b1;
        else begin
          e.da   = a[63:3];
          e.strb = 8'(((1 << n) - 1) << off);
          e.data = wd << (8 * off);
          mq.push_back(e);
          expWr.push_back(e);
        end
      end
    end
    #1;
  endtask

  // Monitor: compares every cycle's combinational outputs and each accepted drain.
  always @(negedge clk) begin : monitor
    chk_t c;
    ent_t e;
    if (chkQ.size() != 0) begin
      c = chkQ.pop_front();
      checkOutput("dmem_rdata", bus.dmem_rdata, c.rdata);
      checkOutput("mem_rd_addr", bus.mem_rd_addr, c.rdAddr);
      checkOutput("mem_wr_valid", 64'(bus.mem_wr_valid), 64'(c.valid));
      checkOutput("sb_count", 64'(sbCount), 64'(c.count));
      checkOutput("sb_full", 64'(sbFull), 64'(c.count == 3'(DEPTH)));
      checkOutput("sb_empty", 64'(sbEmpty), 64'(c.count == 3'd0));
      checkOutput("err_misaligned", 64'(errMis), 64'(c.mis));
      checkOutput("err_overflow", 64'(errOvf), 64'(c.ovf));
    end
    if (bus.mem_wr_valid === 1'b1 && bus.mem_wr_ready === 1'b1) begin
      if (expWr.size() == 0) begin
        checkOutput("unexpected_drain", 64'd1, 64'd0);
      end else begin
        e = expWr.pop_front();
        checkOutput("mem_wr_addr", bus.mem_wr_addr, {e.da, 3'b000});
        checkOutput("mem_wr_data", bus.mem_wr_data, e.data);
        checkOutput("mem_wr_strb", 64'(bus.mem_wr_strb), 64'(e.strb));
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.dmem_we = 1'b0;
    bus.dmem_size = 3'd0;
    bus.dmem_addr = 64'h100;
    bus.dmem_wdata = 64'd0;
    bus.mem_wr_ready = 1'b0;
    bus.mem_rd_data = 64'd0;
    mMis = 1'b0;
    mOvf = 1'b0;
    ram[0] = 64'h8877665544332211;
    for (int i = 1; i < 4; i++) ram[i] = {$urandom, $urandom};
    repeat (2) @(posedge clk);
    #1;

    // Sign and zero extension from raw RAM
    applyStimulus(0, 0, 3'd0, 64'h107, 64'd0, 0);
    applyStimulus(0, 0, 3'd4, 64'h107, 64'd0, 0);
    applyStimulus(0, 0, 3'd1, 64'h106, 64'd0, 0);
    applyStimulus(0, 0, 3'd6, 64'h104, 64'd0, 0);

    // Forwarding with the younger halfword overriding lane 3, then drain
    applyStimulus(0, 1, 3'd0, 64'h103, 64'hAB, 0);
    applyStimulus(0, 1, 3'd1, 64'h102, 64'h1234, 0);
    applyStimulus(0, 0, 3'd3, 64'h100, 64'd0, 0);
    repeat (3) applyStimulus(0, 0, 3'd3, 64'h100, 64'd0, 1);

    // Overflow, full-with-pop acceptance and pointer wrap
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 1, 3'd3, 64'h100 + 64'(8 * (i % 4)), {$urandom, $urandom}, 0);
    applyStimulus(0, 1, 3'd3, 64'h110, {$urandom, $urandom}, 1);
    repeat (6) applyStimulus(0, 0, 3'd3, 64'h110, 64'd0, 1);

    // Misaligned store and load
    applyStimulus(0, 1, 3'd2, 64'h102, 64'hDEADBEEF, 1);
    applyStimulus(0, 0, 3'd2, 64'h102, 64'd0, 1);

    // Reset in the middle of a drain
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, 3'd3, 64'h108 + 64'(8 * i), {$urandom, $urandom}, 0);
    applyStimulus(0, 0, 3'd3, 64'h108, 64'd0, 1);
    applyStimulus(0, 0, 3'd3, 64'h108, 64'd0, 0);
    applyStimulus(1, 0, 3'd3, 64'h108, 64'd0, 1);
    applyStimulus(0, 0, 3'd3, 64'h108, 64'd0, 1);
    applyStimulus(0, 0, 3'd3, 64'h110, 64'd0, 0);

    // Randomized traffic in a four-dword window
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), 64'h100 + 64'($urandom_range(0, 31)),
                    {$urandom, $urandom}, 1'($urandom_range(0, 1)));

    repeat (DEPTH + 2) applyStimulus(0, 0, 3'd3, 64'h100, 64'd0, 1);
    checkOutput("drain_left", 64'(expWr.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
